// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO pair.
// One multiplier/quotient bit per cycle, sign fix-up and HI/LO write in a final cycle.
module mips_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;     // product / quotient sign
    logic               rneg_q, rneg_d;   // remainder sign
    logic               bz_q, bz_d;       // divisor was zero
    logic [WIDTH-1:0]   a_q, a_d;         // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]   m_q, m_d;         // |b|: multiplicand or divisor
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               last_iter;

    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Shift-add: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, dividend bits shifting into quotient}
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod      = neg_q ? -acc_q : acc_q;
    assign quo       = acc_q[WIDTH-1:0];
    assign rem       = acc_q[2*WIDTH-1:WIDTH];
    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    // Next-state: handshake, iteration and HI/LO update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bz_d     = bz_q;
        a_d      = a_q;
        m_d      = m_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = op[1] ? StDiv : StMul;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    bz_d     = (b == '0);
                    a_d      = a;
                    m_d      = b_mag;
                    acc_d    = {{WIDTH{1'b0}}, a_mag};
                    dz_d     = 1'b0;
                end else begin
                    // Start wins over direct writes in the same cycle
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            StMul: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = StFix;
            end
            StDiv: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (bz_q) begin
                    lo_d = '1;
                    hi_d = a_q;
                    dz_d = 1'b1;
                end else begin
                    lo_d = neg_q ? -quo : quo;
                    hi_d = rneg_q ? -rem : rem;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers: synchronous reset, frozen while clk_enable is low
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            a_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else if (clk_enable) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bz_q     <= bz_d;
            a_q      <= a_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mips_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, clk_enable, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
        .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails < 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic from the instruction definitions
    function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh, output logic [31:0] rl,
                                   output logic rz);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rz = 1'b0;
        case (o)
            2'b00: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
            default: begin
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF; rz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sx / sy; r = sx % sy;
                    rl = q[31:0]; rh = r[31:0];
                end else begin
                    rl = x / y; rh = x % y;
                end
            end
        endcase
    endfunction

    // Model: architectural HI/LO plus "result lands WIDTH+1 enabled edges after accept"
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    int          m_left = 0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_left = 0;
            m_valid = 1'b1;
        end else if (clk_enable) begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    ref_op(op, a, b, p_hi, p_lo, p_dz);
                    m_busy = 1'b1;
                    m_left = 33;
                    m_dz   = 1'b0;
                end else begin
                    if (mthi) m_hi = wdata;
                    if (mtlo) m_lo = wdata;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
                    m_busy = 1'b0; m_done = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            cmp("busy", {63'b0, busy}, {63'b0, m_busy});
            cmp("done", {63'b0, done}, {63'b0, m_done});
            cmp("hi", {32'b0, hi}, {32'b0, m_hi});
            cmp("lo", {32'b0, lo}, {32'b0, m_lo});
            cmp("div_by_zero", {63'b0, div_by_zero}, {63'b0, m_dz});
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles until done, bounded
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            if (busy) cyc++;
            @(negedge clk);
        end
        cmp("done_seen", {63'b0, done}, 64'd1);
    endtask

    int cyc;

    initial begin
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp("rst_busy", {63'b0, busy}, 64'd0);
        cmp("rst_hi", {32'b0, hi}, 64'd0);
        cmp("rst_lo", {32'b0, lo}, 64'd0);
        cmp("rst_dz", {63'b0, div_by_zero}, 64'd0);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc);
        cmp("multu_latency", 64'(cyc), 64'd33);
        cmp("multu_hi", {32'b0, hi}, 64'hFFFF_FFFE);
        cmp("multu_lo", {32'b0, lo}, 64'h0000_0001);
        @(negedge clk);
        cmp("done_one_cycle", {63'b0, done}, 64'd0);

        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc);
        cmp("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        cmp("mult_lo", {32'b0, lo}, 64'hFFFF_FFF1);

        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        cmp("div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        cmp("div_hi", {32'b0, hi}, 64'hFFFF_FFFF);

        issue(2'b11, 32'd100, 32'd0);
        wait_done(cyc);
        cmp("divz_lo", {32'b0, lo}, 64'hFFFF_FFFF);
        cmp("divz_hi", {32'b0, hi}, 64'h0000_0064);
        cmp("divz_flag", {63'b0, div_by_zero}, 64'd1);

        issue(2'b01, 32'd2, 32'd3);
        cmp("dz_cleared", {63'b0, div_by_zero}, 64'd0);
        wait_done(cyc);
        cmp("mul6_hi", {32'b0, hi}, 64'd0);
        cmp("mul6_lo", {32'b0, lo}, 64'd6);

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        cmp("ovf_lo", {32'b0, lo}, 64'h8000_0000);
        cmp("ovf_hi", {32'b0, hi}, 64'd0);
        cmp("ovf_dz", {63'b0, div_by_zero}, 64'd0);

        // Start + mthi while busy are ignored; reset mid-operation discards it
        issue(2'b01, 32'd7, 32'd9);
        repeat (8) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("midrst_busy", {63'b0, busy}, 64'd0);
        cmp("midrst_hi", {32'b0, hi}, 64'd0);
        cmp("midrst_lo", {32'b0, lo}, 64'd0);
        issue(2'b01, 32'd7, 32'd9);
        wait_done(cyc);
        cmp("rerun_lo", {32'b0, lo}, 64'd63);
        cmp("rerun_hi", {32'b0, hi}, 64'd0);

        // Direct writes, start beating mtlo, and clock-enable stalls
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        cmp("mthi_write", {32'b0, hi}, 64'h1234_5678);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        cmp("mtlo_dropped", {32'b0, lo}, 64'd63);
        cmp("start_won", {63'b0, busy}, 64'd1);
        fork
            begin
                repeat (10) @(negedge clk);
                clk_enable = 1'b0;
                repeat (5) @(negedge clk);
                clk_enable = 1'b1;
            end
        join_none
        wait_done(cyc);
        cmp("stall_latency", 64'(cyc), 64'd38);
        cmp("stall_lo", {32'b0, lo}, 64'd12);
        cmp("stall_hi", {32'b0, hi}, 64'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Parametrised, iterative multiply/divide unit owning the HI/LO register pair for the MIPS core. It executes MULT, MULTU, DIV and DIVU over WIDTH-bit operands, one bit per cycle, with a start/busy/done handshake. It also supports direct MTHI/MTLO writes. It replaces the single-cycle HI/LO path in the datapath: the core issues an operation, then stalls MFHI/MFLO on `busy`.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width (≥4)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- clk_enable  in  1  when low, all state frozen (no iteration, no HI/LO write, outputs hold)
- start  in  1  issue request; accepted only in IDLE with clk_enable high
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a, b  in  WIDTH each  rs/rt operands; sampled with start
- mthi, mtlo  in  1 each  direct write of wdata into HI/LO
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, results valid
- hi, lo  out  WIDTH each  HI/LO registers
- div_by_zero  out  1  last divide had b==0; held until next accepted start

## Operation

- States: IDLE, MUL, DIV, FIX.
- IDLE + start: latch |a|, |b| (magnitudes for signed ops), result signs, op; clear counter; go to MUL or DIV. Unsigned ops use raw values.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator; WIDTH iterations, then FIX.
- DIV: restoring division, one quotient bit per cycle; WIDTH iterations, then FIX.
- FIX: apply sign correction and write HI/LO; pulse done; return to IDLE.
- Results:
  - Multiply: {hi,lo} = full 2·WIDTH product; negate if sign(a)^sign(b) for MULT.
  - Divide: lo = quotient, hi = remainder. DIV sign rules: quotient sign = sign(a)^sign(b); remainder sign = sign(a), i.e. truncation toward zero.
- b==0 on DIV/DIVU: same latency, no sign correction; lo = all ones, hi = a; div_by_zero=1.
- DIV of most-negative value by −1 wraps: lo = 1000…0, hi = 0; no flag.
- mthi/mtlo in IDLE: write wdata to hi/lo at the edge.
  - Both may be asserted together.
  - If start is asserted in the same cycle, start wins and mthi/mtlo are dropped.
  - Ignored while busy.
- start while busy: ignored; the operation in flight is unaffected.
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Takes effect mid-operation; a partial result is discarded.

## Timing

- Start accepted at edge E0. busy=1 from after E0 until E_{WIDTH+1}.
- Iterations occupy edges E1..E_WIDTH. HI/LO are written at E_{WIDTH+1}.
- After E_{WIDTH+1}: busy=0 and done=1 for exactly one enabled cycle; hi/lo hold new values.
- Total latency: start edge to result visible = WIDTH+1 enabled cycles (33 at WIDTH=32).
- A new start is accepted in the done cycle (back-to-back issue, period WIDTH+2).
- hi/lo are unchanged during busy until E_{WIDTH+1}; MFHI/MFLO during busy read the old values.
- clk_enable low stretches every state, including the done pulse, by the disabled cycles. reset overrides clk_enable.
- mthi/mtlo have single-cycle write latency: new value visible after the edge.

## Test plan

- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (−3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (−7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1. Next MULTU 2×3 -> div_by_zero=0, hi=0, lo=6.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Start MULTU 7×9, pulse start with other operands and assert mthi at cycle 10, assert reset at cycle 20 -> second start and mthi ignored; after reset hi=lo=0, busy=0. Re-run gives lo=63 with no residue.
- In IDLE, mthi=1 and wdata=0x12345678, then mtlo=1 and start=1 together -> hi=0x12345678; mtlo dropped and the operation proceeds. Toggle clk_enable low for 5 cycles mid-op -> done arrives 5 cycles later with a correct result.
